twos_comp_pipe: RTL and testbench

- Parametrised, pipelined two's-complement unit. Successor to the fixed-width 5/8/9/10/25-bit negators.
- Supports selectable modes: pass, negate, absolute value, and sign-controlled negate.
- The +1 carry ripples through WIDTH in SEG_W-bit segments, one segment per pipeline stage, so wide operands meet timing.
- Sits between the FP ALU alignment/normalise datapath and the mantissa adder, with valid/ready handshakes on both sides.

---
 rtl/twos_comp_pkg.sv | 17 +
 rtl/twos_comp_seg.sv | 14 +
 rtl/twos_comp_pipe.sv | 133 +++++++++++++
 tb/tb_twos_comp_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/twos_comp_pkg.sv
// Shared definitions for the pipelined two's-complement unit:
// mode encodings and the stage-count helper.
package twos_comp_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_NEG  = 2'b01,
    OP_ABS  = 2'b10,
    OP_CNEG = 2'b11
  } op_e;

  // Number of SEG_W-bit segments needed to cover WIDTH bits (ceiling division).
  function automatic int nseg(input int width, input int seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/twos_comp_seg.sv
// One increment segment: adds a single carry into SEG_W bits and reports
// the carry out to the next segment. Purely combinational.
module twos_comp_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] seg_in,
  input  logic             carry_in,
  output logic [SEG_W-1:0] seg_out,
  output logic             carry_out
);

  assign {carry_out, seg_out} = {1'b0, seg_in} + {{SEG_W{1'b0}}, carry_in};

endmodule

// File: rtl/twos_comp_pipe.sv
// Pipelined pass/negate/abs/conditional-negate unit. The +1 of the negation
// ripples one SEG_W-bit segment per stage; per-stage valid/ready flow control.
module twos_comp_pipe
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op,
  input  logic             neg_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = nseg(WIDTH, SEG_W);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] data_q    [NSEG];
  logic [WIDTH-1:0] stage_in  [NSEG];
  logic [WIDTH-1:0] stage_nxt [NSEG];
  logic [NSEG-1:0]  valid_q;
  logic [NSEG-1:0]  carry_q;
  logic [NSEG-1:0]  ovf_q;
  logic [NSEG-1:0]  cin;
  logic [NSEG-1:0]  carry_nxt;
  logic [NSEG-1:0]  ready;

  op_e  op_sel;
  logic negate;

  assign op_sel = op_e'(op);

  // NOTE: assigning a default before the case keeps this block free of latches.
  always_comb begin
    negate = 1'b0;
    case (op_sel)
      OP_PASS: negate = 1'b0;
      OP_NEG:  negate = 1'b1;
      OP_ABS:  negate = data_in[WIDTH-1];
      OP_CNEG: negate = neg_ctl;
      default: negate = 1'b0;
    endcase
  end

  // Stage j increments segment j; lower segments are already final, upper ones
  // still wait for their carry.
  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    localparam int LO = j * SEG_W;
    localparam int SW = (j == NSEG - 1) ? (WIDTH - LO) : SEG_W;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << LO;

    logic [SW-1:0] seg_sum;

    if (j == 0) begin : g_first
      assign stage_in[j] = negate ? ~data_in : data_in;
      assign cin[j]      = negate;
    end else begin : g_rest
      assign stage_in[j] = data_q[j-1];
      assign cin[j]      = carry_q[j-1];
    end

    twos_comp_seg #(.SEG_W(SW)) u_seg (
      .seg_in    (stage_in[j][LO +: SW]),
      .carry_in  (cin[j]),
      .seg_out   (seg_sum),
      .carry_out (carry_nxt[j])
    );

    assign stage_nxt[j] = (stage_in[j] & ~MASK) | (WIDTH'(seg_sum) << LO);
  end

  // NOTE: blocking assignments are correct here: r is a combinational temporary
  // carrying ready backwards from the output toward stage 0.
  always_comb begin
    logic r;
    r     = out_ready;
    ready = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      r        = !valid_q[k] || r;
      ready[k] = r;
    end
  end

  // NOTE: non-blocking assignments for all state so every stage samples the
  // pre-edge value of its predecessor. Data registers are reset too because
  // data_out is a direct view of the last stage and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < NSEG; k++) data_q[k] <= '0;
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0]  <= stage_nxt[0];
          carry_q[0] <= carry_nxt[0];
          ovf_q[0]   <= negate && (data_in == MOST_NEG);
        end
      end
      for (int k = 1; k < NSEG; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k]  <= stage_nxt[k];
            carry_q[k] <= carry_nxt[k];
            ovf_q[k]   <= ovf_q[k-1];
          end
        end
      end
    end
  end

  // The carry out of the top segment is the discarded bit of the wrap.
  logic unused_carry;
  assign unused_carry = carry_q[NSEG-1];

  assign in_ready  = ready[0];
  assign out_valid = valid_q[NSEG-1];
  assign data_out  = data_q[NSEG-1];
  assign ovf       = ovf_q[NSEG-1];
  assign zero      = valid_q[NSEG-1] && (data_q[NSEG-1] == '0);

endmodule

// File: tb/tb_twos_comp_pipe.sv
// Directed bench for twos_comp_pipe: 25/8 main instance plus 10/10 and 9/4
// instances for the degenerate and odd-top-segment configurations.
module tb_twos_comp_pipe;
  import twos_comp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Main instance, WIDTH=25 SEG_W=8
  logic        in_valid0 = 1'b0, in_ready0, neg_ctl0 = 1'b0, out_valid0, out_ready0 = 1'b1;
  logic        ovf0, zero0;
  logic [1:0]  op0 = 2'b00;
  logic [24:0] data_in0 = '0, data_out0;

  twos_comp_pipe #(.WIDTH(25), .SEG_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .data_in(data_in0), .op(op0), .neg_ctl(neg_ctl0), .out_valid(out_valid0),
    .out_ready(out_ready0), .data_out(data_out0), .ovf(ovf0), .zero(zero0)
  );

  // Sweep instances share control inputs
  logic       iv_s = 1'b0, neg_s = 1'b0, ordy_s = 1'b1;
  logic [1:0] op_s = 2'b00;
  logic       in_ready1, out_valid1, ovf1, zero1;
  logic       in_ready2, out_valid2, ovf2, zero2;
  logic [9:0] data_in1 = '0, data_out1;
  logic [8:0] data_in2 = '0, data_out2;

  twos_comp_pipe #(.WIDTH(10), .SEG_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(in_ready1),
    .data_in(data_in1), .op(op_s), .neg_ctl(neg_s), .out_valid(out_valid1),
    .out_ready(ordy_s), .data_out(data_out1), .ovf(ovf1), .zero(zero1)
  );

  twos_comp_pipe #(.WIDTH(9), .SEG_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(in_ready2),
    .data_in(data_in2), .op(op_s), .neg_ctl(neg_s), .out_valid(out_valid2),
    .out_ready(ordy_s), .data_out(data_out2), .ovf(ovf2), .zero(zero2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One beat through the 25-bit instance with out_ready held high.
  task automatic run_one(input string tag, input logic [1:0] op_v, input logic nc,
                         input logic [24:0] x, input logic [24:0] exp_d,
                         input logic exp_ovf, input logic exp_zero);
    int cnt;
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    op0        = op_v;
    neg_ctl0   = nc;
    data_in0   = x;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    data_in0  = 25'h155AA55;
    op0       = OP_NEG;
    cnt = 1;
    while (!out_valid0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_lat"},  cnt,       4);
    check({tag, "_data"}, data_out0, exp_d);
    check({tag, "_ovf"},  ovf0,      exp_ovf);
    check({tag, "_zero"}, zero0,     exp_zero);
  endtask

  // Reference: negation as 0 - x, truncated to w bits.
  function automatic logic [9:0] model(input logic [1:0] o, input logic nc,
                                       input logic [9:0] x, input int w,
                                       output logic ov);
    logic       neg;
    logic [9:0] mask, mn, xm;
    mask = (10'd1 << w) - 10'd1;
    mn   = 10'd1 << (w - 1);
    xm   = x & mask;
    case (o)
      2'b00:   neg = 1'b0;
      2'b01:   neg = 1'b1;
      2'b10:   neg = xm[w-1];
      default: neg = nc;
    endcase
    ov = neg && (xm == mn);
    return neg ? ((10'd0 - xm) & mask) : xm;
  endfunction

  task automatic run_sweep(input logic [1:0] o, input logic nc,
                           input logic [9:0] x10, input logic [8:0] x9);
    int         cnt, l1, l2;
    logic       o1, z1, o2, z2, e_o1, e_o2;
    logic [9:0] d1, d2, e1, e2;
    e1 = model(o, nc, x10, 10, e_o1);
    e2 = model(o, nc, {1'b0, x9}, 9, e_o2);
    d1 = '0; d2 = '0; o1 = 1'b0; o2 = 1'b0; z1 = 1'b0; z2 = 1'b0;
    @(posedge clk); #1;
    iv_s = 1'b1; op_s = o; neg_s = nc; data_in1 = x10; data_in2 = x9;
    @(posedge clk); #1;
    iv_s = 1'b0;
    cnt = 1; l1 = 0; l2 = 0;
    while ((l1 == 0 || l2 == 0) && cnt < 12) begin
      if (out_valid1 && l1 == 0) begin l1 = cnt; d1 = data_out1; o1 = ovf1; z1 = zero1; end
      if (out_valid2 && l2 == 0) begin l2 = cnt; d2 = {1'b0, data_out2}; o2 = ovf2; z2 = zero2; end
      if (l1 == 0 || l2 == 0) begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    check("w10_lat",  l1, 1);
    check("w10_data", d1, e1);
    check("w10_ovf",  o1, e_o1);
    check("w10_zero", z1, e1 == 10'd0);
    check("w9_lat",   l2, 3);
    check("w9_data",  d2, e2);
    check("w9_ovf",   o2, e_o2);
    check("w9_zero",  z2, e2 == 10'd0);
  endtask

  // Streaming vectors with hand-computed results
  logic [1:0]  s_op  [8] = '{OP_NEG, OP_PASS, OP_CNEG, OP_CNEG, OP_ABS, OP_NEG, OP_ABS, OP_NEG};
  logic        s_nc  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [24:0] s_x   [8] = '{25'h0000003, 25'h0ABCDEF, 25'h0000100, 25'h0000100,
                             25'h1FFFF00, 25'h1000000, 25'h0123456, 25'h00000FF};
  logic [24:0] s_exp [8] = '{25'h1FFFFFD, 25'h0ABCDEF, 25'h1FFFF00, 25'h0000100,
                             25'h0000100, 25'h1000000, 25'h0123456, 25'h1FFFF01};
  logic        s_ovf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          acc_i, got, inflight, spurious;
    logic        acc, emit, stall_prev, prev_ovf;
    logic [24:0] prev_d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_data_out",  data_out0,  25'h0);
    check("rst_ovf",       ovf0,       1'b0);
    check("rst_zero",      zero0,      1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready0, 1'b1);

    // Single beats
    run_one("neg_one",  OP_NEG,  1'b0, 25'h0000001, 25'h1FFFFFF, 1'b0, 1'b0);
    run_one("neg_zero", OP_NEG,  1'b0, 25'h0000000, 25'h0000000, 1'b0, 1'b1);
    run_one("abs_min",  OP_ABS,  1'b0, 25'h1000000, 25'h1000000, 1'b1, 1'b0);
    run_one("abs_m10",  OP_ABS,  1'b0, 25'h1FFFFF6, 25'h000000A, 1'b0, 1'b0);
    run_one("abs_pos",  OP_ABS,  1'b0, 25'h0000005, 25'h0000005, 1'b0, 1'b0);
    run_one("pass_min", OP_PASS, 1'b0, 25'h1000000, 25'h1000000, 1'b0, 1'b0);
    run_one("cneg_off", OP_CNEG, 1'b0, 25'h0000100, 25'h0000100, 1'b0, 1'b0);
    run_one("neg_256",  OP_NEG,  1'b0, 25'h0000100, 25'h1FFFF00, 1'b0, 1'b0);

    // Streaming with back-pressure
    acc_i = 0; got = 0; inflight = 0; stall_prev = 1'b0; prev_d = '0; prev_ovf = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      out_ready0 = pat[c % 4];
      if (acc_i < 8) begin
        in_valid0 = 1'b1;
        op0       = s_op[acc_i];
        neg_ctl0  = s_nc[acc_i];
        data_in0  = s_x[acc_i];
      end else begin
        in_valid0 = 1'b0;
      end
      @(negedge clk);
      check("stream_in_ready", in_ready0, !(inflight == 4 && !out_ready0));
      if (stall_prev) begin
        check("stall_valid", out_valid0, 1'b1);
        check("stall_data",  data_out0,  prev_d);
        check("stall_ovf",   ovf0,       prev_ovf);
      end
      acc  = in_valid0 && in_ready0;
      emit = out_valid0 && out_ready0;
      if (emit) begin
        check("stream_data", data_out0, s_exp[got]);
        check("stream_ovf",  ovf0,      s_ovf[got]);
        got++;
      end
      stall_prev = out_valid0 && !out_ready0;
      prev_d     = data_out0;
      prev_ovf   = ovf0;
      @(posedge clk);
      inflight = inflight + int'(acc) - int'(emit);
      if (acc) acc_i++;
      #1;
    end
    check("stream_count", got, 8);
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("stream_drain", out_valid0, 1'b0);

    // Reset with three beats in flight
    out_ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid0 = 1'b1;
      op0       = OP_PASS;
      data_in0  = 25'(i + 1);
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid0, 1'b1);
    check("pre_rst_data",  data_out0,  25'h0000001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid0, 1'b0);
    check("mid_rst_data",  data_out0,  25'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    out_ready0 = 1'b1;
    spurious   = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid0) spurious++;
    end
    check("post_rst_quiet", spurious, 0);
    run_one("post_rst", OP_NEG, 1'b0, 25'h0000002, 25'h1FFFFFE, 1'b0, 1'b0);

    // Parameter sweep: boundary operands plus random ones, every op
    for (int o = 0; o < 4; o++) begin
      for (int nc = 0; nc < 2; nc++) begin
        run_sweep(2'(o), 1'(nc), 10'h000, 9'h000);
        run_sweep(2'(o), 1'(nc), 10'h200, 9'h100);
        run_sweep(2'(o), 1'(nc), 10'h3FF, 9'h1FF);
        run_sweep(2'(o), 1'(nc), 10'($urandom_range(1023)), 9'($urandom_range(511)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
